// File: rtl/read_return_tracker.sv
// Read return tracker: queues issued READs with their issue timestamp, captures the returning
// DQ burst CAS_LATENCY cycles later, rotates beats into critical-word-first line order and
// queues completed lines for the cache over valid/ready.
// Optional statistics outputs are enabled by defining RRT_STATS_EN.
module read_return_tracker #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned CAS_LATENCY = 22,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned RESP_DEPTH  = 2,
  parameter int unsigned PADDR_BITS  = 64,
  parameter int unsigned COL_BITS    = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          issue_valid_in,
  output logic                          issue_ready_out,
  input  logic [PADDR_BITS-1:0]         issue_paddr_in,
  input  logic [COL_BITS-1:0]           issue_col_in,
  input  logic [DATA_W-1:0]             dq_in,
  output logic                          bursting_out,
  output logic                          resp_valid_out,
  input  logic                          resp_ready_in,
  output logic [PADDR_BITS-1:0]         resp_paddr_out,
  output logic [BURST_LEN*DATA_W-1:0]   resp_data_out,
  output logic                          timing_err_out,
  output logic                          overrun_err_out
`ifdef RRT_STATS_EN
  ,
  output logic [31:0]                   stat_lines_out,
  output logic [$clog2(DEPTH):0]        stat_max_occ_out
`endif
);

  localparam int unsigned BeatW     = $clog2(BURST_LEN);
  localparam int unsigned AddrW     = $clog2(DEPTH);
  localparam int unsigned RespAddrW = $clog2(RESP_DEPTH);
  localparam int unsigned LineW     = BURST_LEN * DATA_W;

  localparam logic [CNT_W-1:0]     DueAge   = CNT_W'(CAS_LATENCY - 1);
  localparam logic [CNT_W-1:0]     LateAge  = CNT_W'(CAS_LATENCY);
  localparam logic [CNT_W-1:0]     CntInc   = CNT_W'(1);
  localparam logic [BeatW-1:0]     BeatLast = BeatW'(BURST_LEN - 1);
  localparam logic [BeatW-1:0]     BeatOne  = BeatW'(1);
  localparam logic [AddrW-1:0]     PtrOne   = AddrW'(1);
  localparam logic [AddrW:0]       OccOne   = (AddrW + 1)'(1);
  localparam logic [AddrW:0]       OccFull  = (AddrW + 1)'(DEPTH);
  localparam logic [RespAddrW-1:0] RPtrOne  = RespAddrW'(1);
  localparam logic [RespAddrW:0]   ROccOne  = (RespAddrW + 1)'(1);
  localparam logic [RespAddrW:0]   ROccFull = (RespAddrW + 1)'(RESP_DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StCapture} state_e;

  state_e state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q;

  // Outstanding READ FIFO; only the start-beat bits of the column are needed.
  logic [PADDR_BITS-1:0] rd_paddr_mem [DEPTH];
  logic [BeatW-1:0]      rd_col_mem   [DEPTH];
  logic [CNT_W-1:0]      rd_ts_mem    [DEPTH];
  logic [AddrW-1:0]      rd_wptr_q, rd_rptr_q;
  logic [AddrW:0]        rd_cnt_q;
  logic                  rd_full, rd_empty, rd_push, rd_pop;

  logic [CNT_W-1:0] head_age, next_age;
  logic [BeatW-1:0] slot;
  logic             complete, timing_set;

  logic [DATA_W-1:0] line_q [BURST_LEN];
  logic [LineW-1:0]  line_cur;

  logic [PADDR_BITS-1:0] resp_paddr_mem [RESP_DEPTH];
  logic [LineW-1:0]      resp_line_mem  [RESP_DEPTH];
  logic [RespAddrW-1:0]  resp_wptr_q, resp_rptr_q;
  logic [RespAddrW:0]    resp_cnt_q;
  logic                  resp_full, resp_push, resp_pop, overrun_set;

  logic timing_err_q, overrun_err_q;

  logic unused_col_hi;
  assign unused_col_hi = ^issue_col_in;

  assign rd_full  = (rd_cnt_q == OccFull);
  assign rd_empty = (rd_cnt_q == '0);
  // A push is taken when full only if the head retires in the same cycle.
  assign rd_push  = issue_valid_in && (!rd_full || rd_pop);
  assign rd_pop   = complete;

  assign head_age = cnt_q - rd_ts_mem[rd_rptr_q];
  assign next_age = cnt_q - rd_ts_mem[rd_rptr_q + PtrOne];
  assign slot     = rd_col_mem[rd_rptr_q] + beat_q;

  // Free-running timestamp counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_q + CntInc;
  end

  // Read FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (rd_push) rd_wptr_q <= rd_wptr_q + PtrOne;
      if (rd_pop)  rd_rptr_q <= rd_rptr_q + PtrOne;
      if (rd_push && !rd_pop)      rd_cnt_q <= rd_cnt_q + OccOne;
      else if (!rd_push && rd_pop) rd_cnt_q <= rd_cnt_q - OccOne;
    end
  end

  // Read FIFO storage
  always_ff @(posedge clk_in) begin
    if (rd_push) begin
      rd_paddr_mem[rd_wptr_q] <= issue_paddr_in;
      rd_col_mem[rd_wptr_q]   <= issue_col_in[BeatW-1:0];
      rd_ts_mem[rd_wptr_q]    <= cnt_q;
    end
  end

  // FSM state and beat counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next state: wait for the head's data window, capture a burst, retire it
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    complete   = 1'b0;
    timing_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rd_empty) state_d = StWait;
      end
      StWait: begin
        if (rd_empty) begin
          state_d = StIdle;
        end else if (head_age == DueAge) begin
          state_d = StCapture;
          beat_d  = '0;
        end else if (head_age >= LateAge) begin
          timing_set = 1'b1;
          state_d    = StCapture;
          beat_d     = '0;
        end
      end
      StCapture: begin
        beat_d = beat_q + BeatOne;
        if (beat_q == BeatLast) begin
          complete = 1'b1;
          beat_d   = '0;
          // Chain straight into the next burst when its first beat is next cycle.
          if (rd_cnt_q > OccOne && next_age == DueAge) state_d = StCapture;
          else if (rd_cnt_q > OccOne || issue_valid_in) state_d = StWait;
          else                                          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line assembly view including the beat sampled this cycle
  always_comb begin
    line_cur = '0;
    for (int i = 0; i < BURST_LEN; i++) begin
      if (state_q == StCapture && slot == BeatW'(i)) line_cur[i*DATA_W +: DATA_W] = dq_in;
      else                                           line_cur[i*DATA_W +: DATA_W] = line_q[i];
    end
  end

  // Beat capture into critical-word-first slot
  always_ff @(posedge clk_in) begin
    if (state_q == StCapture) line_q[slot] <= dq_in;
  end

  assign resp_full   = (resp_cnt_q == ROccFull);
  assign resp_pop    = resp_valid_out && resp_ready_in;
  assign resp_push   = complete && (!resp_full || resp_pop);
  assign overrun_set = complete && resp_full && !resp_pop;

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_wptr_q <= '0;
      resp_rptr_q <= '0;
      resp_cnt_q  <= '0;
    end else begin
      if (resp_push) resp_wptr_q <= resp_wptr_q + RPtrOne;
      if (resp_pop)  resp_rptr_q <= resp_rptr_q + RPtrOne;
      if (resp_push && !resp_pop)      resp_cnt_q <= resp_cnt_q + ROccOne;
      else if (!resp_push && resp_pop) resp_cnt_q <= resp_cnt_q - ROccOne;
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk_in) begin
    if (resp_push) begin
      resp_paddr_mem[resp_wptr_q] <= rd_paddr_mem[rd_rptr_q];
      resp_line_mem[resp_wptr_q]  <= line_cur;
    end
  end

  // Sticky error flags
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timing_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      if (timing_set)  timing_err_q  <= 1'b1;
      if (overrun_set) overrun_err_q <= 1'b1;
    end
  end

  // Storage is not reset, so response fields are forced to zero while empty.
  assign resp_valid_out  = (resp_cnt_q != '0);
  assign resp_paddr_out  = resp_valid_out ? resp_paddr_mem[resp_rptr_q] : '0;
  assign resp_data_out   = resp_valid_out ? resp_line_mem[resp_rptr_q] : '0;
  assign issue_ready_out = !rd_full;
  assign bursting_out    = (state_q == StCapture);
  assign timing_err_out  = timing_err_q;
  assign overrun_err_out = overrun_err_q;

`ifdef RRT_STATS_EN
  logic [31:0]    lines_q;
  logic [AddrW:0] max_occ_q;

  // Completed-line counter (saturating) and peak read-FIFO occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lines_q   <= '0;
      max_occ_q <= '0;
    end else begin
      if (complete && lines_q != '1) lines_q <= lines_q + 32'd1;
      if (rd_cnt_q > max_occ_q)      max_occ_q <= rd_cnt_q;
    end
  end

  assign stat_lines_out   = lines_q;
  assign stat_max_occ_out = max_occ_q;
`endif

endmodule
